// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART: data register (TX write / RX read) and status register.
// Independent TX and RX state machines, with sticky error flags cleared by a status read.
module uart_periph #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        CE_UART,
    input  logic        CE_SR,
    input  logic        UART_WR,
    input  logic        UART_RD,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    input  logic        rx,
    output logic        tx
);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    logic data_wr, data_rd, stat_rd;
    assign data_wr = CE_UART & UART_WR;
    assign data_rd = CE_UART & UART_RD;
    assign stat_rd = CE_SR & UART_RD;

    logic unused_wdata;
    assign unused_wdata = ^WriteData[31:8];

    tx_state_t   tx_state, tx_state_next;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_idx;
    logic [7:0]  tx_shift;
    logic        tx_bit_end, tx_accept, tx_busy;

    assign tx_bit_end = (tx_cnt == BIT_LAST);
    assign tx_accept  = data_wr & (tx_state == TX_IDLE);
    assign tx_busy    = (tx_state != TX_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state <= TX_IDLE;
        else        tx_state <= tx_state_next;
    end

    always_comb begin
        tx_state_next = tx_state;
        tx            = 1'b1;
        case (tx_state)
            TX_IDLE:  if (tx_accept) tx_state_next = TX_START;
            TX_START: begin
                tx = 1'b0;
                if (tx_bit_end) tx_state_next = TX_DATA;
            end
            TX_DATA: begin
                tx = tx_shift[tx_idx];
                if (tx_bit_end && tx_idx == 3'd7) tx_state_next = TX_STOP;
            end
            TX_STOP:  if (tx_bit_end) tx_state_next = TX_IDLE;
            default:  tx_state_next = TX_IDLE;
        endcase
    end

    // Baud counter reloads at the end of every bit; the bit index only advances in DATA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
        end else if (tx_accept) begin
            tx_shift <= WriteData[7:0];
            tx_cnt   <= '0;
            tx_idx   <= '0;
        end else if (tx_state != TX_IDLE) begin
            if (tx_bit_end) begin
                tx_cnt <= '0;
                if (tx_state == TX_DATA) tx_idx <= tx_idx + 3'd1;
            end else begin
                tx_cnt <= tx_cnt + 16'd1;
            end
        end
    end

    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    rx_state_t   rx_state, rx_state_next;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_idx;
    logic [7:0]  rx_shift;
    logic        rx_fall, rx_sample, rx_done;

    assign rx_fall   = rx_prev & ~rx_sync;
    assign rx_sample = (rx_state == RX_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == BIT_LAST);
    assign rx_done   = (rx_state == RX_STOP) & rx_sample;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_state_next;
    end

    always_comb begin
        rx_state_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_state_next = RX_START;
            RX_START: if (rx_sample) rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_sample && rx_idx == 3'd7) rx_state_next = RX_STOP;
            RX_STOP:  if (rx_sample) rx_state_next = RX_IDLE;
            default:  rx_state_next = RX_IDLE;
        endcase
    end

    // Counter is held at zero in IDLE so the start-bit half period begins at the falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else if (rx_state == RX_IDLE) begin
            rx_cnt <= '0;
            rx_idx <= '0;
        end else if (rx_sample) begin
            rx_cnt <= '0;
            if (rx_state == RX_DATA) begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                rx_idx   <= rx_idx + 3'd1;
            end
        end else begin
            rx_cnt <= rx_cnt + 16'd1;
        end
    end

    logic [7:0] rx_data;
    logic       rx_valid, rx_ovr, frame_err, tx_ovr;

    // Setting a flag takes priority over the read that would clear it in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_ovr    <= 1'b0;
            frame_err <= 1'b0;
            tx_ovr    <= 1'b0;
        end else begin
            if (rx_done && (!rx_valid || data_rd)) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (data_rd) begin
                rx_valid <= 1'b0;
            end

            if (rx_done && rx_valid && !data_rd) rx_ovr <= 1'b1;
            else if (stat_rd)                    rx_ovr <= 1'b0;

            if (rx_done && !rx_sync) frame_err <= 1'b1;
            else if (stat_rd)        frame_err <= 1'b0;

            if (data_wr && tx_busy) tx_ovr <= 1'b1;
            else if (stat_rd)       tx_ovr <= 1'b0;
        end
    end

    always_comb begin
        ReadData = 32'b0;
        if (data_rd)      ReadData = {24'b0, rx_data};
        else if (stat_rd) ReadData = {27'b0, tx_ovr, frame_err, rx_ovr, tx_busy, rx_valid};
    end

endmodule

// File: tb/tb_uart_periph.sv
// Directed testbench for uart_periph at 16 clocks per bit: TX framing, RX framing,
// overrun / framing / false-start handling and reset behaviour.
module tb_uart_periph;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        CE_UART, CE_SR, UART_WR, UART_RD;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        rx;
    logic        tx;

    int checks = 0;
    int errors = 0;

    uart_periph #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .CE_UART   (CE_UART),
        .CE_SR     (CE_SR),
        .UART_WR   (UART_WR),
        .UART_RD   (UART_RD),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .rx        (rx),
        .tx        (tx)
    );

    always #5 clk = ~clk;

    // Expected line level for frame bit k (0 = start, 1..8 = data LSB first, 9+ = stop/idle).
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    task automatic cpu_write(input logic [7:0] data);
        @(negedge clk);
        CE_UART   = 1'b1;
        UART_WR   = 1'b1;
        WriteData = {24'hDEAD_BE, data};
        @(negedge clk);
        CE_UART   = 1'b0;
        UART_WR   = 1'b0;
        WriteData = '0;
    endtask

    task automatic cpu_read(input logic status, output logic [31:0] data);
        @(negedge clk);
        CE_SR   = status;
        CE_UART = !status;
        UART_RD = 1'b1;
        #1 data = ReadData;
        @(negedge clk);
        CE_SR   = 1'b0;
        CE_UART = 1'b0;
        UART_RD = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] data, input logic stop, input int idle);
        for (int k = 0; k < 10; k++) begin
            rx = (k == 9) ? stop : frame_bit(data, k);
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (idle) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        CE_UART = 1'b0; CE_SR = 1'b1; UART_WR = 1'b0; UART_RD = 1'b1;
        WriteData = '0; rx = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_tx: got %b expected 1", tx);
        end
        checks++;
        if (ReadData !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_status: got %h expected 00000000", ReadData);
        end
        repeat (3) @(negedge clk);
        CE_SR = 1'b0; UART_RD = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_tx_frame;
        int bad [10];
        int busy_cycles = 0;
        for (int b = 0; b < 10; b++) bad[b] = 0;
        cpu_write(8'hA5);
        CE_SR = 1'b1; UART_RD = 1'b1;
        for (int k = 0; k < 180; k++) begin
            #1;
            if (ReadData[1] === 1'b1) busy_cycles++;
            if (k < 160 && tx !== frame_bit(8'hA5, k / CPB)) bad[k / CPB]++;
            if (k >= 160 && tx !== 1'b1) bad[9]++;
            @(negedge clk);
        end
        CE_SR = 1'b0; UART_RD = 1'b0;
        for (int b = 0; b < 10; b++) begin
            checks++;
            if (bad[b] != 0) begin
                errors++; $display("[TB] FAIL tx_a5_bit%0d: %0d wrong cycles, expected 0", b, bad[b]);
            end
        end
        checks++;
        if (busy_cycles != 160) begin
            errors++; $display("[TB] FAIL tx_busy_cycles: got %0d expected 160", busy_cycles);
        end
    endtask

    task automatic test_rx_single;
        logic [31:0] d;
        send_rx(8'h3C, 1'b1, 20);
        cpu_read(1'b1, d);
        checks++;
        if (d !== 32'h1) begin
            errors++; $display("[TB] FAIL rx_status_valid: got %h expected 00000001", d);
        end
        @(negedge clk);
        CE_UART = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (ReadData !== 32'h0) begin
            errors++; $display("[TB] FAIL ram_access_readdata: got %h expected 00000000", ReadData);
        end
        CE_UART = 1'b0;
        cpu_read(1'b0, d);
        checks++;
        if (d !== 32'h3C) begin
            errors++; $display("[TB] FAIL rx_data_3c: got %h expected 0000003c", d);
        end
        cpu_read(1'b1, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("[TB] FAIL rx_status_cleared: got %h expected 00000000", d);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        send_rx(8'h11, 1'b1, 0);
        send_rx(8'h22, 1'b1, 20);
        cpu_read(1'b1, d);
        checks++;
        if (d !== 32'h5) begin
            errors++; $display("[TB] FAIL b2b_status: got %h expected 00000005", d);
        end
        cpu_read(1'b0, d);
        checks++;
        if (d !== 32'h11) begin
            errors++; $display("[TB] FAIL b2b_data: got %h expected 00000011", d);
        end
        cpu_read(1'b1, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("[TB] FAIL b2b_status_cleared: got %h expected 00000000", d);
        end
    endtask

    task automatic test_false_start_frame_err;
        logic [31:0] d;
        @(negedge clk);
        rx = 1'b0;
        repeat (6) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        cpu_read(1'b1, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("[TB] FAIL false_start_status: got %h expected 00000000", d);
        end
        send_rx(8'h55, 1'b0, 20);
        cpu_read(1'b1, d);
        checks++;
        if (d !== 32'h9) begin
            errors++; $display("[TB] FAIL frame_err_status: got %h expected 00000009", d);
        end
        cpu_read(1'b0, d);
        checks++;
        if (d !== 32'h55) begin
            errors++; $display("[TB] FAIL frame_err_data: got %h expected 00000055", d);
        end
        cpu_read(1'b1, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("[TB] FAIL frame_err_cleared: got %h expected 00000000", d);
        end
    endtask

    task automatic test_tx_overrun;
        logic [31:0] d;
        int bad = 0;
        cpu_write(8'hC3);
        for (int k = 0; k < 170; k++) begin
            if (k == 40) begin
                CE_UART = 1'b1; UART_WR = 1'b1; WriteData = 32'h0000_0000;
            end else if (k == 41) begin
                CE_UART = 1'b0; UART_WR = 1'b0;
            end
            #1;
            if (tx !== frame_bit(8'hC3, k / CPB)) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("[TB] FAIL tx_ovr_frame: %0d wrong cycles, expected 0", bad);
        end
        cpu_read(1'b1, d);
        checks++;
        if (d !== 32'h10) begin
            errors++; $display("[TB] FAIL tx_ovr_status: got %h expected 00000010", d);
        end
        cpu_read(1'b1, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("[TB] FAIL tx_ovr_cleared: got %h expected 00000000", d);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] d;
        cpu_write(8'h00);
        rx = 1'b0;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        rx = 1'b1;
        CE_SR = 1'b1; UART_RD = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1) begin
            errors++; $display("[TB] FAIL midreset_tx: got %b expected 1", tx);
        end
        checks++;
        if (ReadData !== 32'h0) begin
            errors++; $display("[TB] FAIL midreset_status: got %h expected 00000000", ReadData);
        end
        repeat (3) @(negedge clk);
        CE_SR = 1'b0; UART_RD = 1'b0;
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        cpu_read(1'b1, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("[TB] FAIL post_reset_status: got %h expected 00000000", d);
        end
        cpu_read(1'b0, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("[TB] FAIL post_reset_data: got %h expected 00000000", d);
        end
        cpu_write(8'h5A);
        #1;
        checks++;
        if (tx !== 1'b0) begin
            errors++; $display("[TB] FAIL post_reset_start_bit: got %b expected 0", tx);
        end
        cpu_read(1'b1, d);
        checks++;
        if (d !== 32'h2) begin
            errors++; $display("[TB] FAIL post_reset_busy: got %h expected 00000002", d);
        end
        repeat (170) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_tx_frame;
        test_rx_single;
        test_back_to_back;
        test_false_start_frame_err;
        test_tx_overrun;
        test_reset_mid_frame;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
